// File: rtl/pe_tile_scheduler_pkg.sv
// Shared state encoding and default index widths for the PE tile scheduler.
package pe_sched_pkg;

  localparam int DEF_ROW_BITS  = 8;
  localparam int DEF_COL_BITS  = 8;
  localparam int DEF_ITER_BITS = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_RELEASE,
    ST_WB,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/pe_tile_scheduler_if.sv
// Scheduler-facing bundle: layer config, IA/W load requests, PE start/finish, OA write-back.
interface pe_tile_scheduler_if #(
  parameter int ROW_BITS  = pe_sched_pkg::DEF_ROW_BITS,
  parameter int COL_BITS  = pe_sched_pkg::DEF_COL_BITS,
  parameter int ITER_BITS = pe_sched_pkg::DEF_ITER_BITS
);

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [ROW_BITS-1:0]  cfg_rows;
  logic [COL_BITS-1:0]  cfg_cols;
  logic [ITER_BITS-1:0] cfg_w_iters;
  logic                 abort;
  logic                 ia_req;
  logic [ROW_BITS-1:0]  ia_row;
  logic [COL_BITS-1:0]  ia_col;
  logic                 ia_ack;
  logic                 w_req;
  logic [ITER_BITS-1:0] w_iter;
  logic                 w_ack;
  logic                 pe_start;
  logic                 pe_finish;
  logic                 oa_req;
  logic [ROW_BITS-1:0]  oa_row;
  logic [COL_BITS-1:0]  oa_col;
  logic                 oa_ack;
  logic                 busy;
  logic                 done;

  modport master (
    input  cfg_valid, cfg_rows, cfg_cols, cfg_w_iters, abort,
    input  ia_ack, w_ack, pe_finish, oa_ack,
    output cfg_ready, ia_req, ia_row, ia_col, w_req, w_iter,
    output pe_start, oa_req, oa_row, oa_col, busy, done
  );

  modport slave (
    output cfg_valid, cfg_rows, cfg_cols, cfg_w_iters, abort,
    output ia_ack, w_ack, pe_finish, oa_ack,
    input  cfg_ready, ia_req, ia_row, ia_col, w_req, w_iter,
    input  pe_start, oa_req, oa_row, oa_col, busy, done
  );

endinterface

// File: rtl/pe_loop_counter.sv
// Row x column x weight-iteration index counter; inc_tile resets iter and steps col, carrying into row.
module pe_loop_counter #(
  parameter int ROW_BITS  = 8,
  parameter int COL_BITS  = 8,
  parameter int ITER_BITS = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [ROW_BITS-1:0]  rows,
  input  logic [COL_BITS-1:0]  cols,
  input  logic [ITER_BITS-1:0] w_iters,
  input  logic                 clear,
  input  logic                 inc_iter,
  input  logic                 inc_tile,
  output logic [ROW_BITS-1:0]  row,
  output logic [COL_BITS-1:0]  col,
  output logic [ITER_BITS-1:0] iter,
  output logic                 last_iter,
  output logic                 last_tile
);

  logic last_col;

  // Counts are nonzero whenever these are consulted, so count-1 never underflows.
  assign last_iter = (iter == w_iters - ITER_BITS'(1));
  assign last_col  = (col == cols - COL_BITS'(1));
  assign last_tile = last_col && (row == rows - ROW_BITS'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      row  <= '0;
      col  <= '0;
      iter <= '0;
    end else if (inc_tile) begin
      iter <= '0;
      if (last_col) begin
        col <= '0;
        row <= row + ROW_BITS'(1);
      end else begin
        col <= col + COL_BITS'(1);
      end
    end else if (inc_iter) begin
      iter <= iter + ITER_BITS'(1);
    end
  end

endmodule

// File: rtl/pe_tile_scheduler.sv
// Walks rows x cols x w_iters for one PE: load IA/W, run PE start/finish, write back OA per tile.
// Requests hold until acked; each ack/finish edge advances the FSM on the following cycle.
module pe_tile_scheduler
  import pe_sched_pkg::*;
#(
  parameter int ROW_BITS  = DEF_ROW_BITS,
  parameter int COL_BITS  = DEF_COL_BITS,
  parameter int ITER_BITS = DEF_ITER_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  pe_tile_scheduler_if.master  bus
);

  sched_state_t         state, nxt_state;
  logic [ROW_BITS-1:0]  rows_q;
  logic [COL_BITS-1:0]  cols_q;
  logic [ITER_BITS-1:0] iters_q;
  logic [ROW_BITS-1:0]  row;
  logic [COL_BITS-1:0]  col;
  logic [ITER_BITS-1:0] iter;
  logic                 last_iter, last_tile;
  logic                 got_ia, got_w;
  logic                 need_ia, ia_ok, w_ok;
  logic                 cfg_take, cfg_zero;
  logic                 inc_iter, inc_tile;
  logic                 ia_req_c, w_req_c, pe_start_c, oa_req_c, done_c, busy_c, cfg_ready_c;

  assign cfg_take = (state == ST_IDLE) && bus.cfg_valid;
  assign cfg_zero = (bus.cfg_rows == '0) || (bus.cfg_cols == '0) || (bus.cfg_w_iters == '0);
  assign need_ia  = (iter == '0);
  assign ia_ok    = !need_ia || got_ia || bus.ia_ack;
  assign w_ok     = got_w || bus.w_ack;

  pe_loop_counter #(
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS),
    .ITER_BITS(ITER_BITS)
  ) u_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .rows     (rows_q),
    .cols     (cols_q),
    .w_iters  (iters_q),
    .clear    (cfg_take),
    .inc_iter (inc_iter),
    .inc_tile (inc_tile),
    .row      (row),
    .col      (col),
    .iter     (iter),
    .last_iter(last_iter),
    .last_tile(last_tile)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rows_q  <= '0;
      cols_q  <= '0;
      iters_q <= '0;
    end else if (cfg_take) begin
      rows_q  <= bus.cfg_rows;
      cols_q  <= bus.cfg_cols;
      iters_q <= bus.cfg_w_iters;
    end
  end

  // Flags live only within one LOAD visit, so leaving LOAD clears them for the next step.
  always_ff @(posedge i_clk) begin
    if (i_rst || state != ST_LOAD) begin
      got_ia <= 1'b0;
      got_w  <= 1'b0;
    end else begin
      if (ia_req_c && bus.ia_ack) got_ia <= 1'b1;
      if (w_req_c && bus.w_ack)   got_w  <= 1'b1;
    end
  end

  always_comb begin
    nxt_state = state;
    inc_iter  = 1'b0;
    inc_tile  = 1'b0;
    case (state)
      ST_IDLE:    if (bus.cfg_valid) nxt_state = cfg_zero ? ST_DONE : ST_LOAD;
      ST_LOAD:    if (ia_ok && w_ok) nxt_state = ST_RUN;
      ST_RUN:     if (bus.pe_finish) nxt_state = ST_RELEASE;
      ST_RELEASE: begin
        if (!bus.pe_finish) begin
          if (last_iter) begin
            nxt_state = ST_WB;
          end else begin
            nxt_state = ST_LOAD;
            inc_iter  = 1'b1;
          end
        end
      end
      ST_WB: begin
        if (bus.oa_ack) begin
          if (last_tile) begin
            nxt_state = ST_DONE;
          end else begin
            nxt_state = ST_LOAD;
            inc_tile  = 1'b1;
          end
        end
      end
      ST_DONE:    nxt_state = ST_IDLE;
      default:    nxt_state = ST_IDLE;
    endcase
    // DONE is left alone so an abort there cannot stretch the done pulse.
    if (bus.abort && state != ST_IDLE && state != ST_DONE) begin
      nxt_state = ST_DONE;
      inc_iter  = 1'b0;
      inc_tile  = 1'b0;
    end
  end

  always_comb begin
    ia_req_c    = 1'b0;
    w_req_c     = 1'b0;
    pe_start_c  = 1'b0;
    oa_req_c    = 1'b0;
    done_c      = 1'b0;
    busy_c      = (state != ST_IDLE);
    cfg_ready_c = (state == ST_IDLE) && !i_rst;
    case (state)
      ST_LOAD: begin
        ia_req_c = need_ia && !got_ia;
        w_req_c  = !got_w;
      end
      ST_RUN:  pe_start_c = 1'b1;
      ST_WB:   oa_req_c   = 1'b1;
      ST_DONE: done_c     = 1'b1;
      default: ;
    endcase
  end

  assign bus.cfg_ready = cfg_ready_c;
  assign bus.ia_req    = ia_req_c;
  assign bus.w_req     = w_req_c;
  assign bus.pe_start  = pe_start_c;
  assign bus.oa_req    = oa_req_c;
  assign bus.done      = done_c;
  assign bus.busy      = busy_c;
  assign bus.ia_row    = row;
  assign bus.ia_col    = col;
  assign bus.oa_row    = row;
  assign bus.oa_col    = col;
  assign bus.w_iter    = iter;

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Scoreboard bench for pe_tile_scheduler: a negedge responder acks requests and models the PE.
module tb_pe_tile_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_tile_scheduler_if bus();

  pe_tile_scheduler dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d required %0d", tag, got, exp);
    end
  endtask

  logic [15:0] ia_q[$];
  logic [7:0]  w_q[$];
  logic [15:0] oa_q[$];

  int ia_delay = 1, w_delay = 1, fin_delay = 2, fin_hold = 1, oa_allow = 1000;
  int abort_arm = 0;
  int cyc = 0, ia_cnt = 0, w_cnt = 0, oa_cnt = 0, done_cnt = 0, act = 0;
  int ia_ack_neg = 0, w_ack_neg = 0, rise_neg = 0, fall_neg = 0, w_gap = 0;

  task automatic push_exp(input int cols, input int iters, input int n_tiles);
    for (int t = 0; t < n_tiles; t++) begin
      for (int it = 0; it < iters; it++) begin
        if (it == 0) ia_q.push_back({8'(t / cols), 8'(t % cols)});
        w_q.push_back(8'(it));
      end
      oa_q.push_back({8'(t / cols), 8'(t % cols)});
    end
  endtask

  // Responder: PE model, delayed acks, handshake scoreboard, event timestamps.
  initial begin
    int st_cnt, hold_cnt, ia_wait, w_wait;
    logic prev_start, prev_w;
    logic [15:0] e16;
    logic [7:0]  e8;
    st_cnt = 0; hold_cnt = 0; ia_wait = 0; w_wait = 0;
    prev_start = 1'b0; prev_w = 1'b0;
    bus.ia_ack = 1'b0; bus.w_ack = 1'b0; bus.oa_ack = 1'b0;
    bus.pe_finish = 1'b0; bus.abort = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.pe_start) begin
        if (!prev_start) rise_neg = cyc;
        hold_cnt = 0;
        st_cnt++;
        if (st_cnt >= fin_delay) bus.pe_finish = 1'b1;
      end else begin
        st_cnt = 0;
        if (bus.pe_finish) begin
          hold_cnt++;
          if (hold_cnt >= fin_hold) begin
            bus.pe_finish = 1'b0;
            hold_cnt = 0;
            fall_neg = cyc;
          end
        end
      end
      prev_start = bus.pe_start;
      if (bus.w_req && !prev_w) w_gap = cyc - fall_neg;
      prev_w = bus.w_req;
      if (bus.ia_req || bus.w_req || bus.oa_req || bus.pe_start) act++;
      if (bus.done) done_cnt++;
      if (bus.ia_req) begin ia_wait++; bus.ia_ack = (ia_wait >= ia_delay); end
      else begin ia_wait = 0; bus.ia_ack = 1'b0; end
      if (bus.w_req) begin w_wait++; bus.w_ack = (w_wait >= w_delay); end
      else begin w_wait = 0; bus.w_ack = 1'b0; end
      if (abort_arm != 0 && bus.pe_start && bus.ia_row == 8'd1 && bus.ia_col == 8'd0) begin
        bus.abort = 1'b1;
        abort_arm = 0;
      end else begin
        bus.abort = 1'b0;
      end
      // Abort cycle also carries a stray OA ack that must be ignored.
      bus.oa_ack = bus.abort || (bus.oa_req && oa_allow > 0);
      if (bus.ia_req && bus.ia_ack) begin
        ia_cnt++; ia_ack_neg = cyc;
        if (ia_q.size() == 0) chk("ia_unexpected", ia_q.size(), 1);
        else begin e16 = ia_q.pop_front(); chk("ia_rowcol", {bus.ia_row, bus.ia_col}, e16); end
      end
      if (bus.w_req && bus.w_ack) begin
        w_cnt++; w_ack_neg = cyc;
        if (w_q.size() == 0) chk("w_unexpected", w_q.size(), 1);
        else begin e8 = w_q.pop_front(); chk("w_iter", bus.w_iter, e8); end
      end
      if (bus.oa_req && bus.oa_ack) begin
        oa_cnt++; oa_allow--;
        if (oa_q.size() == 0) chk("oa_unexpected", oa_q.size(), 1);
        else begin e16 = oa_q.pop_front(); chk("oa_rowcol", {bus.oa_row, bus.oa_col}, e16); end
      end
    end
  end

  task automatic send_cfg(input int r, input int c, input int w);
    for (int i = 0; i < 200 && bus.cfg_ready !== 1'b1; i++) @(negedge clk);
    chk("cfg_ready_wait", bus.cfg_ready, 1);
    bus.cfg_valid = 1'b1;
    bus.cfg_rows = 8'(r);
    bus.cfg_cols = 8'(c);
    bus.cfg_w_iters = 6'(w);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic chk_sb_empty(input string tag);
    chk(tag, ia_q.size() + w_q.size() + oa_q.size(), 0);
  endtask

  initial begin
    int d0, a0, o0, w0, i0;
    bus.cfg_valid = 1'b0; bus.cfg_rows = '0; bus.cfg_cols = '0; bus.cfg_w_iters = '0;

    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", bus.cfg_ready, 0);
    chk("rst_outs", {bus.busy, bus.done, bus.ia_req, bus.w_req, bus.pe_start, bus.oa_req}, 0);
    chk("rst_idx", {bus.ia_row, bus.ia_col, 2'b00, bus.w_iter}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cfg_ready", bus.cfg_ready, 1);

    // Full 2x2x3 layer with immediate acks.
    push_exp(2, 3, 4);
    d0 = done_cnt; w0 = w_cnt; i0 = ia_cnt; o0 = oa_cnt;
    send_cfg(2, 2, 3);
    wait_done("full_done", d0);
    chk("full_w_cnt", w_cnt - w0, 12);
    chk("full_ia_cnt", ia_cnt - i0, 4);
    chk("full_oa_cnt", oa_cnt - o0, 4);
    chk_sb_empty("full_sb_empty");

    // W ack three cycles ahead of IA ack.
    ia_delay = 4; w_delay = 1;
    push_exp(1, 1, 1);
    d0 = done_cnt;
    send_cfg(1, 1, 1);
    wait_done("ooo_done", d0);
    chk("ooo_ack_gap", ia_ack_neg - w_ack_neg, 3);
    chk("ooo_start", rise_neg - ia_ack_neg, 1);

    // Both acks in the same cycle after a delay.
    ia_delay = 3; w_delay = 3;
    push_exp(1, 1, 1);
    d0 = done_cnt;
    send_cfg(1, 1, 1);
    wait_done("same_done", d0);
    chk("same_ack_gap", ia_ack_neg - w_ack_neg, 0);
    chk("same_start", rise_neg - w_ack_neg, 1);
    ia_delay = 1; w_delay = 1;

    // PE keeps finish high 5 cycles after start drops.
    fin_hold = 5;
    push_exp(1, 2, 1);
    d0 = done_cnt;
    send_cfg(1, 1, 2);
    wait_done("hold_done", d0);
    chk("hold_wreq_gap", w_gap, 1);
    chk_sb_empty("hold_sb_empty");
    fin_hold = 1;

    // Zero counts complete immediately with no activity.
    a0 = act;
    send_cfg(3, 2, 0);
    chk("zero_done", bus.done, 1);
    chk("zero_reqs", {bus.ia_req, bus.w_req, bus.pe_start, bus.oa_req}, 0);
    @(negedge clk);
    chk("zero_done_drop", bus.done, 0);
    chk("zero_ready", bus.cfg_ready, 1);
    send_cfg(0, 5, 5);
    chk("zero_rows_done", bus.done, 1);
    @(negedge clk);
    chk("zero_activity", act - a0, 0);

    // Abort during RUN at tile (1,0) with simultaneous finish and stray OA ack.
    push_exp(2, 3, 2);
    ia_q.push_back({8'd1, 8'd0});
    w_q.push_back(8'd0);
    fin_delay = 1; abort_arm = 1;
    d0 = done_cnt; o0 = oa_cnt;
    send_cfg(2, 2, 3);
    for (int i = 0; i < 2000 && bus.abort !== 1'b1; i++) @(posedge clk);
    chk("abort_seen", bus.abort, 1);
    #1;
    chk("abort_start", bus.pe_start, 0);
    chk("abort_done", bus.done, 1);
    chk("abort_reqs", {bus.ia_req, bus.w_req, bus.oa_req}, 0);
    @(posedge clk); #1;
    chk("abort_ready", bus.cfg_ready, 1);
    chk("abort_idle", {bus.busy, bus.done}, 0);
    repeat (3) @(negedge clk);
    chk("abort_done_pulses", done_cnt - d0, 1);
    chk("abort_oa_cnt", oa_cnt - o0, 2);
    chk_sb_empty("abort_sb_empty");
    fin_delay = 2;

    // Reset pulsed while waiting in WB on tile (0,1).
    push_exp(2, 1, 1);
    ia_q.push_back({8'd0, 8'd1});
    w_q.push_back(8'd0);
    oa_allow = 1;
    d0 = done_cnt;
    send_cfg(2, 2, 1);
    for (int i = 0; i < 2000 && !(bus.oa_req === 1'b1 && bus.oa_col === 8'd1); i++) @(negedge clk);
    chk("rst_wb_reached", bus.oa_col, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", bus.cfg_ready, 0);
    chk("mid_rst_outs", {bus.busy, bus.done, bus.ia_req, bus.w_req, bus.pe_start, bus.oa_req}, 0);
    chk("mid_rst_idx", {bus.oa_row, bus.oa_col, 2'b00, bus.w_iter}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_release", bus.cfg_ready, 1);
    repeat (3) @(negedge clk);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk_sb_empty("mid_rst_sb_empty");

    oa_allow = 1000;
    push_exp(1, 1, 1);
    d0 = done_cnt;
    send_cfg(1, 1, 1);
    chk("restart_req", {bus.ia_req, bus.w_req}, 2'b11);
    chk("restart_idx", {bus.ia_row, bus.ia_col, 2'b00, bus.w_iter}, 0);
    wait_done("restart_done", d0);
    chk_sb_empty("restart_sb_empty");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
